adc_mem_arbiter: RTL and testbench
==================================

# adc_mem_arbiter

Two-port round-robin arbiter that shares the single-port 32-bit on-chip sample memory (DEPTH words, 1-cycle read latency, byte enables) between the ADC capture writer (port 0) and the host/Avalon access path (port 1). Sits between both requesters and the memory instance. It issues at most one memory access per cycle, returns read data tagged to the correct port, and blocks out-of-range addresses.

## Interface
- DEPTH, 10000, number of valid memory words; addresses >= DEPTH are out of range
- AW, 14, address width
- clk  in  1  single clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- pause  in  1  high: no new grants; memory clock enable low
- clr_err  in  1  one-cycle pulse clears err_oor
- mN_read, mN_write (N=0,1)  in  1  request strobes; held until accepted
- mN_address  in  AW  word address
- mN_writedata  in  32  write data
- mN_byteenable  in  4  byte lanes for writes
- mN_waitrequest  out  1  high = request not accepted this cycle
- mN_readdata  out  32  read data
- mN_readdatavalid  out  1  one-cycle pulse, readdata valid
- mem_address  out  AW  to memory
- mem_byteenable  out  4  to memory
- mem_chipselect, mem_write  out  1  to memory
- mem_writedata  out  32  to memory
- mem_clken  out  1  memory clock enable (= ~pause)
- mem_readdata  in  32  memory output, valid 1 cycle after read issue
- err_oor  out  1  sticky: an out-of-range access occurred

## Operation
- Request from port N = mN_read | mN_write; read and write both high is illegal (treated as write).
- Grant each cycle (combinational from requests and priority pointer `last`): only one requester -> it wins; both -> the port != last wins; pause or reset_n low -> none.
- Granted port: mN_waitrequest=0 that cycle; others 1. Non-requesting port waitrequest=1.
- On grant, `last` <= granted port (register). Back-to-back requests from both ports strictly alternate 0,1,0,1...
- Granted access drives mem_address/byteenable/writedata from winner; mem_chipselect=1, mem_write=winner's write, unless address >= DEPTH.
- Out-of-range: grant still consumed (waitrequest=0); mem_chipselect=0 (write dropped); err_oor set next cycle; a read returns readdata=0 with readdatavalid.
- Read return pipeline: register {valid, port, oor} at issue; next cycle pulse mN_readdatavalid for that port, readdata = mem_readdata (or 0 if oor). Other port's readdatavalid=0, readdata=0.
- err_oor: set on OOR grant; clr_err clears; set and clear same cycle -> set wins.
- Idle memory outputs: chipselect=0, write=0, address/data/byteenable=0.

## Timing
- Reset (reset_n low at edge): last=1 (port 0 wins first tie), read pipeline valid=0, err_oor=0. While reset_n low: all waitrequest=1, readdatavalid=0, mem_chipselect=0, mem_write=0.
- Accept latency: 0 cycles (same-cycle grant when winning). Read latency: readdatavalid exactly 1 cycle after accepting cycle.
- Throughput: one access per cycle; consecutive reads from one port return every cycle.
- pause high: no grants, mem_clken=0; a read accepted the cycle before pause still returns its readdatavalid (memory output held valid).
- Reset mid-read: in-flight readdatavalid suppressed.
- Write then read same address on consecutive cycles: read returns new data.

## Test plan
- Port 0 writes 0xA5A5_0001 to addr 5, be=4'hF; next cycle port 1 reads addr 5 -> m1_waitrequest=0, m1_readdatavalid one cycle later with 0xA5A5_0001; m0_readdatavalid stays 0.
- Both ports request reads continuously for 8 cycles after reset -> grants 0,1,0,1,0,1,0,1; each readdatavalid one cycle after its grant, correct port.
- Port 1 writes 0xFFFF_FFFF to addr 9999 then be=4'b0010 write 0x0000_1200 -> read returns 0xFFFF_12FF.
- Port 0 write to addr 10000 -> mem_chipselect=0, err_oor=1 next cycle; port 0 read addr 12000 -> readdata 0 with valid; clr_err -> err_oor=0.
- pause held 3 cycles with both requesting -> both waitrequest=1, mem_clken=0; on release grant order resumes from stored last.
- Assert reset_n low the cycle after a read is accepted -> no readdatavalid; after release port 0 wins first simultaneous request.

Source files
------------

// File: rtl/adc_mem_arbiter.sv
// -----------------------------------------------------------------------------
// adc_mem_arbiter
//
// Shares one single-port 32-bit sample memory (DEPTH words, 1-cycle read
// latency, byte enables) between two Avalon-style requesters:
//   port 0 : ADC capture writer
//   port 1 : host / Avalon access path
// At most one memory access is issued per cycle. Contention is resolved
// round-robin: when both ports request, the port that did not win last time
// gets the grant. Read data is returned, tagged to the issuing port, exactly
// one cycle after the grant. Accesses at or beyond DEPTH are accepted but
// never reach the memory: they raise the sticky err_oor flag, and reads
// return zero.
//
// Ports
//   clk, reset_n       single clock, synchronous active-low reset
//   pause              blocks new grants and drops the memory clock enable
//   clr_err            one-cycle pulse that clears err_oor
//   mN_*  (N = 0, 1)   requester ports: read/write strobes (held until
//                      accepted), address, writedata, byteenable,
//                      waitrequest, readdata, readdatavalid
//   mem_*              memory-side address, byteenable, chipselect, write,
//                      writedata, clken (outputs) and readdata (input)
//   err_oor            sticky out-of-range access flag
// -----------------------------------------------------------------------------
module adc_mem_arbiter #(
  parameter int DEPTH = 10000,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pause,
  input  logic          clr_err,

  // Port 0: ADC capture writer
  input  logic          m0_read,
  input  logic          m0_write,
  input  logic [AW-1:0] m0_address,
  input  logic [31:0]   m0_writedata,
  input  logic [3:0]    m0_byteenable,
  output logic          m0_waitrequest,
  output logic [31:0]   m0_readdata,
  output logic          m0_readdatavalid,

  // Port 1: host / Avalon access path
  input  logic          m1_read,
  input  logic          m1_write,
  input  logic [AW-1:0] m1_address,
  input  logic [31:0]   m1_writedata,
  input  logic [3:0]    m1_byteenable,
  output logic          m1_waitrequest,
  output logic [31:0]   m1_readdata,
  output logic          m1_readdatavalid,

  // Memory side
  output logic [AW-1:0] mem_address,
  output logic [3:0]    mem_byteenable,
  output logic          mem_chipselect,
  output logic          mem_write,
  output logic [31:0]   mem_writedata,
  output logic          mem_clken,
  input  logic [31:0]   mem_readdata,

  output logic          err_oor
);

  // One extra bit so the limit is representable even when DEPTH == 2**AW.
  localparam logic [AW:0] ADDR_LIMIT = (AW + 1)'(DEPTH);

  // ---------------------------------------------------------------------------
  // Request decode and round-robin grant
  // ---------------------------------------------------------------------------
  logic req0;
  logic req1;
  logic gnt0;
  logic gnt1;
  logic any_gnt;
  logic last;        // port that won the most recent grant

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset_n && !pause) begin
      // Port 0 wins when alone, or on a tie when port 1 was the last winner.
      if (req0 && (!req1 || last)) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign any_gnt        = gnt0 | gnt1;
  assign m0_waitrequest = ~gnt0;
  assign m1_waitrequest = ~gnt1;

  // ---------------------------------------------------------------------------
  // Winner mux and range check
  // ---------------------------------------------------------------------------
  logic [AW-1:0] win_address;
  logic [31:0]   win_writedata;
  logic [3:0]    win_byteenable;
  logic          win_write;
  logic          win_is_read;
  logic          win_oor;

  always_comb begin
    if (gnt1) begin
      win_address    = m1_address;
      win_writedata  = m1_writedata;
      win_byteenable = m1_byteenable;
      win_write      = m1_write;
      win_is_read    = m1_read & ~m1_write;
    end else begin
      win_address    = m0_address;
      win_writedata  = m0_writedata;
      win_byteenable = m0_byteenable;
      win_write      = m0_write;
      win_is_read    = m0_read & ~m0_write;
    end
  end

  // Read and write both asserted is illegal; the write takes precedence.
  assign win_oor = ({1'b0, win_address} >= ADDR_LIMIT);

  // ---------------------------------------------------------------------------
  // Memory-side drive: quiet bus when idle, chipselect masked for OOR
  // ---------------------------------------------------------------------------
  assign mem_address    = any_gnt ? win_address    : '0;
  assign mem_writedata  = any_gnt ? win_writedata  : '0;
  assign mem_byteenable = any_gnt ? win_byteenable : '0;
  assign mem_chipselect = any_gnt & ~win_oor;
  assign mem_write      = any_gnt & ~win_oor & win_write;

  // With the clock enable low the memory holds its output register, which
  // keeps a read issued just before pause valid through the return cycle.
  assign mem_clken = ~pause;

  // ---------------------------------------------------------------------------
  // Sequential state: priority pointer, read-return tag, sticky error
  // ---------------------------------------------------------------------------
  logic rd_valid;    // a read was issued on the previous cycle
  logic rd_port;     // which port issued it
  logic rd_oor;      // it was out of range: return zero

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last     <= 1'b1;    // port 0 wins the first tie after reset
      rd_valid <= 1'b0;
      rd_port  <= 1'b0;
      rd_oor   <= 1'b0;
      err_oor  <= 1'b0;
    end else begin
      if (any_gnt) begin
        last <= gnt1;
      end
      rd_valid <= any_gnt & win_is_read;
      rd_port  <= gnt1;
      rd_oor   <= win_oor;
      // A new out-of-range grant overrides a clear in the same cycle.
      err_oor  <= (err_oor & ~clr_err) | (any_gnt & win_oor);
    end
  end

  // ---------------------------------------------------------------------------
  // Read return: route the registered tag to one port, zero elsewhere
  // ---------------------------------------------------------------------------
  logic        ret_valid;
  logic [31:0] ret_data;

  // Gating with reset_n suppresses a return that was in flight when reset
  // was asserted; the register itself clears on the same edge.
  assign ret_valid = rd_valid & reset_n;
  assign ret_data  = rd_oor ? 32'h0 : mem_readdata;

  assign m0_readdatavalid = ret_valid & ~rd_port;
  assign m1_readdatavalid = ret_valid &  rd_port;
  assign m0_readdata      = m0_readdatavalid ? ret_data : 32'h0;
  assign m1_readdata      = m1_readdatavalid ? ret_data : 32'h0;

endmodule

// File: tb/tb_adc_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adc_mem_arbiter
//
// Drives adc_mem_arbiter with a short directed sequence followed by random
// traffic, against a simple word memory behind the memory port. A
// transaction-level reference model (who should win, what the memory
// should hold, what a read should return) predicts every output each cycle.
// Inputs change on the falling edge; outputs are sampled 2 time units later.
// -----------------------------------------------------------------------------
module tb_adc_mem_arbiter;

  localparam int DEPTH = 10000;
  localparam int AW    = 14;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          pause;
  logic          clr_err;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [AW-1:0] m0_address, m1_address;
  logic [31:0]   m0_writedata, m1_writedata;
  logic [3:0]    m0_byteenable, m1_byteenable;
  logic          m0_waitrequest, m1_waitrequest;
  logic [31:0]   m0_readdata, m1_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic [AW-1:0] mem_address;
  logic [3:0]    mem_byteenable;
  logic          mem_chipselect, mem_write, mem_clken;
  logic [31:0]   mem_writedata;
  logic [31:0]   mem_readdata;
  logic          err_oor;

  adc_mem_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .pause            (pause),
    .clr_err          (clr_err),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_address       (m0_address),
    .m0_writedata     (m0_writedata),
    .m0_byteenable    (m0_byteenable),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_address       (m1_address),
    .m1_writedata     (m1_writedata),
    .m1_byteenable    (m1_byteenable),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata),
    .err_oor          (err_oor)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
    return r;
  endfunction

  // Memory instance: 1-cycle read latency, output held while clken is low.
  bit [31:0] tb_mem [DEPTH];
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect && int'(mem_address) < DEPTH) begin
      if (mem_write) tb_mem[mem_address] <= merge_bytes(tb_mem[mem_address], mem_writedata, mem_byteenable);
      else           mem_readdata        <= tb_mem[mem_address];
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model (transaction level)
  // ---------------------------------------------------------------------------
  bit [31:0] ref_mem [DEPTH];
  int        m_last      = 1;    // last winner; reset makes port 0 win first tie
  bit        m_pend      = 0;    // read return due this cycle
  int        m_pend_port = 0;
  bit [31:0] m_pend_data = 0;
  bit        m_err       = 0;
  int        exp_gnt     = -1;   // -1 none, else winning port this cycle

  task automatic settle_and_check();
    bit rq0, rq1, oor, wr;
    int g;
    logic [AW-1:0] a;
    bit rdv0, rdv1;
    #2;
    rq0 = m0_read | m0_write;
    rq1 = m1_read | m1_write;
    if (!reset_n || pause)  g = -1;
    else if (rq0 && rq1)    g = (m_last == 0) ? 1 : 0;
    else if (rq0)           g = 0;
    else if (rq1)           g = 1;
    else                    g = -1;
    exp_gnt = g;
    a   = (g == 1) ? m1_address : m0_address;
    wr  = (g == 1) ? m1_write   : m0_write;
    oor = (g >= 0) && (int'(a) >= DEPTH);
    rdv0 = reset_n && m_pend && m_pend_port == 0;
    rdv1 = reset_n && m_pend && m_pend_port == 1;

    check("m0_waitrequest",   m0_waitrequest,   (g != 0));
    check("m1_waitrequest",   m1_waitrequest,   (g != 1));
    check("m0_readdatavalid", m0_readdatavalid, rdv0);
    check("m1_readdatavalid", m1_readdatavalid, rdv1);
    check("m0_readdata",      m0_readdata,      rdv0 ? m_pend_data : 32'h0);
    check("m1_readdata",      m1_readdata,      rdv1 ? m_pend_data : 32'h0);
    check("mem_chipselect",   mem_chipselect,   (g >= 0) && !oor);
    check("mem_write",        mem_write,        (g >= 0) && !oor && wr);
    check("mem_address",      mem_address,      (g >= 0) ? a : '0);
    check("mem_clken",        mem_clken,        !pause);
    check("err_oor",          err_oor,          m_err);
  endtask

  task automatic advance();
    bit oor, wr, rd, nerr;
    logic [AW-1:0] a;
    if (!reset_n) begin
      m_last = 1;
      m_pend = 0;
      m_err  = 0;
    end else begin
      m_pend = 0;
      nerr   = m_err && !clr_err;
      if (exp_gnt >= 0) begin
        a   = (exp_gnt == 1) ? m1_address : m0_address;
        wr  = (exp_gnt == 1) ? m1_write   : m0_write;
        rd  = ((exp_gnt == 1) ? m1_read   : m0_read) && !wr;
        oor = int'(a) >= DEPTH;
        m_last = exp_gnt;
        if (oor) nerr = 1;
        if (wr && !oor)
          ref_mem[a] = merge_bytes(ref_mem[a],
                                   (exp_gnt == 1) ? m1_writedata  : m0_writedata,
                                   (exp_gnt == 1) ? m1_byteenable : m0_byteenable);
        if (rd) begin
          m_pend      = 1;
          m_pend_port = exp_gnt;
          m_pend_data = oor ? 32'h0 : ref_mem[a];
        end
      end
      m_err = nerr;
    end
    @(negedge clk);
  endtask

  task automatic cyc();
    settle_and_check();
    advance();
  endtask

  task automatic set_idle();
    reset_n = 1'b1; pause = 1'b0; clr_err = 1'b0;
    m0_read = 0; m0_write = 0; m0_address = '0; m0_writedata = '0; m0_byteenable = '0;
    m1_read = 0; m1_write = 0; m1_address = '0; m1_writedata = '0; m1_byteenable = '0;
  endtask

  task automatic new_req(input int port);
    bit rd, wr;
    int sel, addr;
    rd = 0; wr = 0;
    if ($urandom_range(0, 99) >= 40) begin
      wr = $urandom_range(0, 1) == 1;
      rd = !wr;
      if ($urandom_range(0, 49) == 0) begin rd = 1; wr = 1; end
    end
    sel = $urandom_range(0, 19);
    if (sel == 0)      addr = DEPTH + $urandom_range(0, 6383);
    else if (sel == 1) addr = DEPTH - 10 + $urandom_range(0, 9);
    else               addr = $urandom_range(0, 31);
    if (port == 0) begin
      m0_read = rd; m0_write = wr; m0_address = AW'(addr);
      m0_writedata = $urandom; m0_byteenable = 4'($urandom_range(0, 15));
    end else begin
      m1_read = rd; m1_write = wr; m1_address = AW'(addr);
      m1_writedata = $urandom; m1_byteenable = 4'($urandom_range(0, 15));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    set_idle();
    reset_n = 1'b0;
    @(negedge clk);
    settle_and_check();
    check("rst_m0_wait", m0_waitrequest, 1'b1);
    check("rst_cs",      mem_chipselect, 1'b0);
    advance();
    cyc();
    reset_n = 1'b1;

    // Write then read the same address on consecutive cycles.
    m0_write = 1; m0_address = 14'd5; m0_writedata = 32'hA5A5_0001; m0_byteenable = 4'hF;
    cyc();
    set_idle();
    m1_read = 1; m1_address = 14'd5;
    settle_and_check();
    check("wr_rd_m1_wait", m1_waitrequest, 1'b0);
    advance();
    set_idle();
    settle_and_check();
    check("wr_rd_m1_rdv",  m1_readdatavalid, 1'b1);
    check("wr_rd_m1_data", m1_readdata, 32'hA5A5_0001);
    check("wr_rd_m0_rdv",  m0_readdatavalid, 1'b0);
    advance();

    // Both ports reading continuously after reset alternate 0,1,0,1...
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    m0_read = 1; m0_address = 14'd5;
    m1_read = 1; m1_address = 14'd6;
    for (int i = 0; i < 8; i++) begin
      settle_and_check();
      check("alt_m0_wait", m0_waitrequest, (i % 2 == 1));
      if (i > 0) check("alt_m0_rdv", m0_readdatavalid, ((i - 1) % 2 == 0));
      advance();
    end
    set_idle();
    settle_and_check();
    check("alt_last_m1_rdv", m1_readdatavalid, 1'b1);
    advance();

    // Byte-lane merge at the top valid address.
    m1_write = 1; m1_address = 14'd9999; m1_writedata = 32'hFFFF_FFFF; m1_byteenable = 4'hF;
    cyc();
    m1_writedata = 32'h0000_1200; m1_byteenable = 4'b0010;
    cyc();
    set_idle();
    m1_read = 1; m1_address = 14'd9999;
    cyc();
    set_idle();
    settle_and_check();
    check("be_merge", m1_readdata, 32'hFFFF_12FF);
    advance();

    // Out-of-range write and read; clr_err.
    m0_write = 1; m0_address = 14'd10000; m0_writedata = 32'h1234_5678; m0_byteenable = 4'hF;
    settle_and_check();
    check("oor_wr_cs",   mem_chipselect, 1'b0);
    check("oor_wr_wait", m0_waitrequest, 1'b0);
    advance();
    set_idle();
    m0_read = 1; m0_address = 14'd12000;
    settle_and_check();
    check("oor_err_set", err_oor, 1'b1);
    advance();
    set_idle();
    settle_and_check();
    check("oor_rd_rdv",  m0_readdatavalid, 1'b1);
    check("oor_rd_data", m0_readdata, 32'h0);
    advance();
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    settle_and_check();
    check("oor_err_clr", err_oor, 1'b0);
    advance();

    // Pause with both requesting; port 0 won last, so port 1 resumes.
    m0_read = 1; m0_address = 14'd1;
    m1_read = 1; m1_address = 14'd2;
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle_and_check();
      check("pause_m0_wait", m0_waitrequest, 1'b1);
      check("pause_m1_wait", m1_waitrequest, 1'b1);
      check("pause_clken",   mem_clken, 1'b0);
      advance();
    end
    pause = 1'b0;
    settle_and_check();
    check("resume_m1_wait", m1_waitrequest, 1'b0);
    check("resume_m0_wait", m0_waitrequest, 1'b1);
    advance();
    set_idle();
    cyc();

    // A read accepted just before pause still returns.
    m0_read = 1; m0_address = 14'd5;
    cyc();
    set_idle();
    pause = 1'b1;
    settle_and_check();
    check("pause_ret_rdv",  m0_readdatavalid, 1'b1);
    check("pause_ret_data", m0_readdata, 32'hA5A5_0001);
    advance();
    pause = 1'b0;

    // Reset right after a read is accepted suppresses its return.
    m0_read = 1; m0_address = 14'd5;
    cyc();
    set_idle();
    reset_n = 1'b0;
    settle_and_check();
    check("rst_mid_rdv", m0_readdatavalid, 1'b0);
    advance();
    reset_n = 1'b1;
    m0_read = 1; m0_address = 14'd3;
    m1_read = 1; m1_address = 14'd4;
    settle_and_check();
    check("post_rst_m0_wait", m0_waitrequest, 1'b0);
    check("post_rst_m1_wait", m1_waitrequest, 1'b1);
    advance();
    set_idle();
    cyc();

    // Random traffic; an unaccepted request is held unchanged.
    new_req(0);
    new_req(1);
    for (int i = 0; i < 2000; i++) begin
      settle_and_check();
      advance();
      if (!(m0_read || m0_write) || exp_gnt == 0) new_req(0);
      if (!(m1_read || m1_write) || exp_gnt == 1) new_req(1);
      pause   = ($urandom_range(0, 9) == 0);
      clr_err = ($urandom_range(0, 19) == 0);
      reset_n = !($urandom_range(0, 99) == 0);
    end
    set_idle();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
